// File: rtl/filter_pkg.sv
// Shared types and constants for the moving-average filter front end.
// Holds the feeder state enum, sample width and underflow counter width.
package filter_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int UFLOW_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } feed_state_e;

endpackage

// File: rtl/filter_sample_feeder_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and a
// first-word-visible head; push when full and pop when empty are ignored.
module sync_fifo
  import filter_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/filter_sample_feeder.sv
// Paced sample feeder ahead of the filter Xn input: FIFO, prime/run FSM, tick.
// Define FEEDER_UFLOW_CNT_EN to add the saturating uflow_cnt port.
module filter_sample_feeder
  import filter_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4,
  parameter int DIV       = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      xn,
  output logic                   xn_strobe,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   underflow
`ifdef FEEDER_UFLOW_CNT_EN
  ,
  output logic [UFLOW_CNT_W-1:0] uflow_cnt
`endif
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  feed_state_e       state;
  feed_state_e       nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              tick;
  logic              pop;
  logic              uf_evt;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .count (fill),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = !full;

  // A dropping enable suppresses the tick so nothing is popped on exit.
  assign tick   = (state == RUN) && en && (cnt == CW'(DIV - 1));
  assign pop    = tick && !empty;
  assign uf_evt = tick && empty;

  always_comb begin
    nxt = state;
    if (!en) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    nxt = PRIME;
        PRIME:   if (fill >= FW'(PRIME_LVL)) nxt = RUN;
        RUN:     if (uf_evt) nxt = PRIME;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (state != RUN || nxt != RUN) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      xn        <= '0;
      xn_strobe <= 1'b0;
      underflow <= 1'b0;
    end else begin
      xn_strobe <= pop;
      underflow <= uf_evt;
      if (!en || uf_evt) begin
        xn <= '0;
      end else if (pop) begin
        xn <= head;
      end
    end
  end

`ifdef FEEDER_UFLOW_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      uflow_cnt <= '0;
    end else if (uf_evt && uflow_cnt != '1) begin
      uflow_cnt <= uflow_cnt + UFLOW_CNT_W'(1);
    end
  end
`endif

endmodule
